// File: rtl/mp_enq_packer.sv
// Gathers single upstream entries into an ENQUEUE_WIDTH-lane batch for a multi-port FIFO.
// A batch is emitted when full or when a partial batch ages out, and it fires all-or-nothing.
module mp_enq_packer #(
  parameter int ENQUEUE_WIDTH = 4,
  parameter int PAYLOAD_WIDTH = 2,
  parameter int TIMEOUT       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_vld_i,
  input  logic [PAYLOAD_WIDTH-1:0]               in_payload_i,
  output logic                                   in_rdy_o,
  output logic [ENQUEUE_WIDTH-1:0]               enqueue_vld_o,
  output logic [ENQUEUE_WIDTH*PAYLOAD_WIDTH-1:0] enqueue_payload_o,
  input  logic [ENQUEUE_WIDTH-1:0]               enqueue_rdy_i,
  input  logic                                   flush_i
);

  localparam int CNT_W = $clog2(ENQUEUE_WIDTH + 1);
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [AGE_W-1:0]         age_q, age_d;
  logic [PAYLOAD_WIDTH-1:0] slot_q [ENQUEUE_WIDTH];

  logic                     accept;
  logic                     fire;
  logic [CNT_W-1:0]         cnt_inc;
  logic [ENQUEUE_WIDTH-1:0] lane_act;

  always_comb begin
    for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
      lane_act[i] = CNT_W'(i) < cnt_q;
    end
  end

  assign in_rdy_o = (state_q == FILL) && (cnt_q < CNT_W'(ENQUEUE_WIDTH)) && !flush_i;
  assign accept   = in_vld_i && in_rdy_o;
  assign cnt_inc  = cnt_q + CNT_W'(accept);
  // Unoccupied lanes are treated as ready so only the live lanes gate the fire.
  assign fire     = (state_q == EMIT) && (&(enqueue_rdy_i | ~lane_act)) && !flush_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    age_d   = age_q;
    if (flush_i) begin
      state_d = FILL;
      cnt_d   = '0;
      age_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          cnt_d = cnt_inc;
          if (cnt_q != '0) begin
            age_d = age_q + AGE_W'(1);
          end
          if ((cnt_inc == CNT_W'(ENQUEUE_WIDTH)) ||
              ((cnt_q != '0) && (age_q == AGE_W'(TIMEOUT - 1)))) begin
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            state_d = FILL;
            cnt_d   = '0;
            age_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
    end
  end

  // NOTE: the slot buffer has no reset; lanes are masked by cnt so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          slot_q[i] <= in_payload_i;
        end
      end
    end
  end

  // Outputs decode straight from reset registers, so rst clears them asynchronously.
  always_comb begin
    enqueue_vld_o     = '0;
    enqueue_payload_o = '0;
    for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
      if ((state_q == EMIT) && lane_act[i]) begin
        enqueue_vld_o[i]                                       = 1'b1;
        enqueue_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]   = slot_q[i];
      end
    end
  end

endmodule

// File: tb/tb_mp_enq_packer.sv
// Directed bench for mp_enq_packer: a per-cycle vector table plus hand-written
// sequences for timeout, all-or-nothing firing, flush during EMIT and reset during EMIT.
module tb_mp_enq_packer;

  logic       clk;
  logic       rst;
  logic       in_vld;
  logic [1:0] in_pay;
  logic       in_rdy;
  logic [3:0] enq_vld;
  logic [7:0] enq_pay;
  logic [3:0] enq_rdy;
  logic       flush;

  int passed = 0;
  int total  = 0;

  mp_enq_packer #(
    .ENQUEUE_WIDTH(4),
    .PAYLOAD_WIDTH(2),
    .TIMEOUT      (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_vld_i         (in_vld),
    .in_payload_i     (in_pay),
    .in_rdy_o         (in_rdy),
    .enqueue_vld_o    (enq_vld),
    .enqueue_payload_o(enq_pay),
    .enqueue_rdy_i    (enq_rdy),
    .flush_i          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] pay;
    logic [3:0] rdy;
    logic       flush;
    logic       exp_in_rdy;
    logic [3:0] exp_vld;
    logic [7:0] exp_pay;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic [3:0] r, input logic f);
    in_vld  = v;
    in_pay  = p;
    enq_rdy = r;
    flush   = f;
  endtask

  // Pushes four entries through consecutive accept edges, ending at the first EMIT cycle.
  task automatic fill4(input logic [1:0] p0, input logic [1:0] p1,
                       input logic [1:0] p2, input logic [1:0] p3, input logic [3:0] r);
    drive(1'b1, p0, r, 1'b0); step();
    drive(1'b1, p1, r, 1'b0); step();
    drive(1'b1, p2, r, 1'b0); step();
    drive(1'b1, p3, r, 1'b0); step();
    drive(1'b0, 2'd0, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'hF, 1'b0);

    // Full batch 0,1,2,3 then fire, then backpressured batch, then flush of a partial batch.
    vecs.push_back('{1'b1, 2'd0, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd1, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd2, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd3, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b0, 1'b0, 4'hF, 8'hE4});
    vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd3, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd3, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd1, 4'h0, 1'b0, 1'b1, 4'h0, 8'h00});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1, 2'd2, 4'h0, 1'b0, 1'b0, 4'hF, 8'h4F});
    vecs.push_back('{1'b1, 2'd2, 4'hF, 1'b0, 1'b0, 4'hF, 8'h4F});
    vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd1, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});
    vecs.push_back('{1'b1, 2'd2, 4'hF, 1'b1, 1'b0, 4'h0, 8'h00});
    vecs.push_back('{1'b0, 2'd0, 4'hF, 1'b0, 1'b1, 4'h0, 8'h00});

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_vld", 32'(enq_vld), 32'h0);
    check("rst_pay", 32'(enq_pay), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", 32'(in_rdy), 32'h1);
    check("post_rst_vld", 32'(enq_vld), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].pay, vecs[i].rdy, vecs[i].flush);
      #1;
      check($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].exp_in_rdy));
      check($sformatf("vec%0d_vld", i), 32'(enq_vld), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_pay", i), 32'(enq_pay), 32'(vecs[i].exp_pay));
      step();
    end

    // Timeout: single entry 2'b10 emerges 8 cycles after its accept edge.
    drive(1'b1, 2'b10, 4'hF, 1'b0);
    step();
    drive(1'b0, 2'd0, 4'hF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("tmo_wait%0d_vld", k), 32'(enq_vld), 32'h0);
      step();
    end
    #1;
    check("tmo_vld", 32'(enq_vld), 32'h1);
    check("tmo_pay", 32'(enq_pay), 32'h02);
    step();
    #1;
    check("tmo_after_in_rdy", 32'(in_rdy), 32'h1);
    check("tmo_after_vld", 32'(enq_vld), 32'h0);

    // All-or-nothing: three entries wait for timeout, lane 2 not ready blocks the fire.
    drive(1'b1, 2'd1, 4'b0011, 1'b0); step();
    drive(1'b1, 2'd2, 4'b0011, 1'b0); step();
    drive(1'b1, 2'd3, 4'b0011, 1'b0); step();
    drive(1'b0, 2'd0, 4'b0011, 1'b0);
    for (int k = 0; k < 20 && enq_vld == 4'h0; k++) step();
    #1;
    check("aon_vld", 32'(enq_vld), 32'h7);
    check("aon_pay", 32'(enq_pay), 32'h39);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check($sformatf("aon_hold%0d_vld", k), 32'(enq_vld), 32'h7);
      check($sformatf("aon_hold%0d_in_rdy", k), 32'(in_rdy), 32'h0);
    end
    enq_rdy = 4'b0111;
    step();
    #1;
    check("aon_fired_vld", 32'(enq_vld), 32'h0);
    check("aon_fired_in_rdy", 32'(in_rdy), 32'h1);

    // Flush during EMIT discards the batch and ignores the flush-cycle input.
    fill4(2'd1, 2'd1, 2'd1, 2'd1, 4'h0);
    #1;
    check("fl_emit_vld", 32'(enq_vld), 32'hF);
    drive(1'b1, 2'd2, 4'h0, 1'b1);
    #1;
    check("fl_in_rdy", 32'(in_rdy), 32'h0);
    step();
    drive(1'b0, 2'd0, 4'h0, 1'b0);
    #1;
    check("fl_after_vld", 32'(enq_vld), 32'h0);
    check("fl_after_in_rdy", 32'(in_rdy), 32'h1);
    fill4(2'd3, 2'd2, 2'd1, 2'd0, 4'h0);
    #1;
    check("fl_refill_vld", 32'(enq_vld), 32'hF);
    check("fl_refill_pay", 32'(enq_pay), 32'h1B);

    // Reset asserted mid-EMIT clears outputs immediately.
    rst = 1'b1;
    #1;
    check("rst_emit_vld", 32'(enq_vld), 32'h0);
    check("rst_emit_pay", 32'(enq_pay), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rst_rel_in_rdy", 32'(in_rdy), 32'h1);
    check("rst_rel_vld", 32'(enq_vld), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mp_enq_packer.md
MP_ENQ_PACKER -- requirements
Module: mp_enq_packer

Interface
REQ-001 SHALL have parameter ENQUEUE_WIDTH, default 4: number of output lanes, and the maximum batch size.
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default 2: bits per entry.
REQ-003 SHALL have parameter TIMEOUT, default 8, legal range >=1: partial-batch age limit in cycles.
REQ-004 SHALL have port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_vld_i  input  1: the upstream entry is valid.
REQ-007 SHALL have port in_payload_i  input  PAYLOAD_WIDTH: the upstream entry.
REQ-008 SHALL have port in_rdy_o  output  1: the packer accepts the entry this cycle.
REQ-009 SHALL have port enqueue_vld_o  output  ENQUEUE_WIDTH: per-lane batch valid.
REQ-010 SHALL have port enqueue_payload_o  output  ENQUEUE_WIDTH*PAYLOAD_WIDTH: lane i occupies bits [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
REQ-011 SHALL have port enqueue_rdy_i  input  ENQUEUE_WIDTH: per-lane downstream ready, as driven by the multi-port FIFO enqueue side.
REQ-012 SHALL have port flush_i  input  1: synchronous discard of the partial or pending batch.

Function
REQ-013 SHALL hold an ENQUEUE_WIDTH-slot buffer, a count cnt (0..ENQUEUE_WIDTH, width $clog2(ENQUEUE_WIDTH+1)) and an age counter (width $clog2(TIMEOUT+1)).
REQ-014 SHALL implement two states, FILL and EMIT; reset state SHALL be FILL.
REQ-015 SHALL drive in_rdy_o = (state==FILL) & (cnt<ENQUEUE_WIDTH) & !flush_i, combinationally.
REQ-016 SHALL treat an accept (in_vld_i & in_rdy_o) as: write in_payload_i into slot cnt, then cnt+1; the first accepted entry of a batch SHALL land in lane 0, preserving arrival order.
REQ-017 SHALL, in FILL, increment age every cycle with cnt>0 and hold age at 0 while cnt==0.
REQ-018 SHALL move FILL->EMIT at the next edge when the post-accept cnt equals ENQUEUE_WIDTH, or when cnt>0 and age==TIMEOUT-1.
REQ-019 SHALL, in EMIT, drive enqueue_vld_o[i]=(i<cnt) and enqueue_payload_o lane i = slot i; lanes i>=cnt SHALL drive 0; in FILL, enqueue_vld_o SHALL be all 0.
REQ-020 SHALL fire the batch only when enqueue_rdy_i[i]==1 for every i<cnt (all-or-nothing; partial lane acceptance SHALL NOT occur).
REQ-021 SHALL hold enqueue_vld_o and enqueue_payload_o stable in EMIT until fire.
REQ-022 SHALL, on fire, set cnt=0 and age=0 and return to FILL at the next edge; in_rdy_o SHALL be 0 during the fire cycle.
REQ-023 SHALL give a full-batch latency of one cycle: the 4th accept at edge N puts enqueue_vld_o=4'b1111 in the cycle after edge N.
REQ-024 SHALL give flush_i priority over accept, fire and timeout: at the next edge cnt=0, age=0, state=FILL, and the batch is not counted as fired.
REQ-025 SHALL never overflow cnt past ENQUEUE_WIDTH and never emit a batch with cnt==0.

Reset
REQ-026 SHALL, while rst=1, asynchronously force state=FILL, cnt=0, age=0, enqueue_vld_o=0 and enqueue_payload_o=0; buffer contents need no reset.
REQ-027 SHALL drive in_rdy_o=1 in the first cycle after rst deasserts (absent flush_i).
REQ-028 SHALL discard a pending batch when rst asserts mid-EMIT, with enqueue_vld_o going 0 immediately.

Verification
REQ-029 SHALL cover a full batch: payloads 0,1,2,3 on 4 consecutive cycles with enqueue_rdy_i=4'hF -> next cycle enqueue_vld_o=4'hF, payload=8'b11_10_01_00, fire, in_rdy_o=1 the following cycle.
REQ-030 SHALL cover timeout: a single entry 2'b10, TIMEOUT=8 -> enqueue_vld_o=4'b0001 appears 8 cycles after the accept, lane 0=2'b10.
REQ-031 SHALL cover backpressure: full batch with enqueue_rdy_i=0 for 5 cycles -> outputs stable, in_rdy_o=0 for those cycles, and exactly one fire when rdy=4'hF.
REQ-032 SHALL cover all-or-nothing: 3-entry batch with enqueue_rdy_i=4'b0011 -> no fire; then 4'b0111 -> fire.
REQ-033 SHALL cover flush: flush_i during EMIT with in_vld_i=1 -> next cycle enqueue_vld_o=0, cnt=0, and the flush-cycle input is not accepted.
REQ-034 SHALL cover reset: rst asserted mid-EMIT -> enqueue_vld_o=0 the same cycle, in_rdy_o=1 after release.
